// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point round/pack stage.
package fp_pkg;

  localparam logic signed [12:0] BIAS_D    = 13'sd1023;
  localparam logic signed [12:0] BIAS_S    = 13'sd127;
  localparam logic signed [12:0] EXP_MAX_D = 13'sd2047;
  localparam logic signed [12:0] EXP_MAX_S = 13'sd255;

  localparam int MW_D    = 53;
  localparam int MW_S_LO = 24;
  localparam int MW_S_HI = 29;

  localparam int F_OVF_HI = 5;
  localparam int F_UNF_HI = 4;
  localparam int F_INX_HI = 3;
  localparam int F_OVF_LO = 2;
  localparam int F_UNF_LO = 1;
  localparam int F_INX_LO = 0;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RUP = 2'd2,
    RM_RDN = 2'd3
  } rmode_t;

endpackage

// File: rtl/fp_lane_round.sv
// Per-lane rounding decision: increment, carry out of the mantissa, inexact.
// Optional directed rounding modes when FP_RND_MODES_EN is defined.
module fp_lane_round
  import fp_pkg::*;
#(
  parameter int MW = 53
) (
  input  logic [MW-1:0] mant,
  input  logic          guard,
  input  logic          sticky,
  input  logic          narrow,
`ifdef FP_RND_MODES_EN
  input  logic          sign,
  input  logic [1:0]    rmode,
`endif
  output logic          inc,
  output logic          carry,
  output logic          inx
);

  logic ones;

  // narrow: a 24-bit single lane sits zero-extended in a wider datapath
  assign ones = narrow ? (&mant[MW_S_LO-1:0]) : (&mant);
  assign inx  = guard | sticky;

`ifdef FP_RND_MODES_EN
  always_comb begin
    inc = 1'b0;
    case (rmode_t'(rmode))
      RM_RNE:  inc = guard & (sticky | mant[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = (guard | sticky) & ~sign;
      RM_RDN:  inc = (guard | sticky) & sign;
      default: inc = 1'b0;
    endcase
  end
`else
  assign inc = guard & (sticky | mant[0]);
`endif

  assign carry = inc & ones;

endmodule

// File: rtl/fp_round_pack.sv
// Round, exponent-adjust and IEEE-754 pack: one double or two singles, 2-stage
// valid/ready pipeline. FP_RND_MODES_EN adds i_rmode (RNE/RTZ/RUP/RDN).
module fp_round_pack
  import fp_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic        i_mode,
  input  logic [52:0] i_res53,
  input  logic [4:0]  i_z24,
  input  logic [4:0]  i_z29,
  input  logic [5:0]  i_z52,
  input  logic [12:0] i_exp_hi,
  input  logic [12:0] i_exp_lo,
  input  logic        i_sign_hi,
  input  logic        i_sign_lo,
  input  logic        i_rnd_hi,
  input  logic        i_stk_hi,
  input  logic        i_rnd_lo,
  input  logic        i_stk_lo,
`ifdef FP_RND_MODES_EN
  input  logic [1:0]  i_rmode,
`endif
  output logic        o_valid,
  input  logic        o_ready,
  output logic [63:0] o_result,
  output logic [5:0]  o_flags
);

  logic s1_v, s1_adv, s2_adv;

  assign s2_adv  = ~o_valid | o_ready;
  assign s1_adv  = ~s1_v | s2_adv;
  assign i_ready = s1_adv;

  logic [52:0] mant_hi;
  logic        g_hi, st_hi;
  logic [12:0] e_hi_d, e_lo_d;
  logic        zero_hi_d, zero_lo_d;
  logic        inc_hi_d, cy_hi_d, inx_hi_d;
  logic        inc_lo_d, cy_lo_d, inx_lo_d;
  logic        sat_hi_d, sat_lo_d;

  assign mant_hi   = i_mode ? i_res53 : {29'd0, i_res53[52:29]};
  assign g_hi      = i_mode ? i_rnd_hi : i_res53[28];
  assign st_hi     = i_mode ? i_stk_hi : ((|i_res53[27:24]) | i_rnd_hi | i_stk_hi);
  assign zero_hi_d = ~|mant_hi;
  assign zero_lo_d = ~|i_res53[23:0];
  assign e_hi_d    = i_exp_hi - (i_mode ? {7'd0, i_z52} : {8'd0, i_z29});
  assign e_lo_d    = i_exp_lo - {8'd0, i_z24};

`ifdef FP_RND_MODES_EN
  // overflow saturates to max finite when rounding points back toward zero
  function automatic logic sat_on_ovf(input logic [1:0] rm, input logic sign);
    case (rmode_t'(rm))
      RM_RTZ:  return 1'b1;
      RM_RUP:  return sign;
      RM_RDN:  return ~sign;
      default: return 1'b0;
    endcase
  endfunction
  assign sat_hi_d = sat_on_ovf(i_rmode, i_sign_hi);
  assign sat_lo_d = sat_on_ovf(i_rmode, i_sign_lo);
`else
  assign sat_hi_d = 1'b0;
  assign sat_lo_d = 1'b0;
`endif

  fp_lane_round #(.MW(MW_D)) u_rnd_hi (
    .mant   (mant_hi),
    .guard  (g_hi),
    .sticky (st_hi),
    .narrow (~i_mode),
`ifdef FP_RND_MODES_EN
    .sign   (i_sign_hi),
    .rmode  (i_rmode),
`endif
    .inc    (inc_hi_d),
    .carry  (cy_hi_d),
    .inx    (inx_hi_d)
  );

  fp_lane_round #(.MW(MW_S_LO)) u_rnd_lo (
    .mant   (i_res53[23:0]),
    .guard  (i_rnd_lo),
    .sticky (i_stk_lo),
    .narrow (1'b0),
`ifdef FP_RND_MODES_EN
    .sign   (i_sign_lo),
    .rmode  (i_rmode),
`endif
    .inc    (inc_lo_d),
    .carry  (cy_lo_d),
    .inx    (inx_lo_d)
  );

  logic        s1_mode, s1_sign_hi, s1_sign_lo;
  logic [12:0] s1_e_hi, s1_e_lo;
  logic [51:0] s1_frac;
  logic        s1_inc_hi, s1_cy_hi, s1_inx_hi, s1_zero_hi, s1_sat_hi;
  logic        s1_inc_lo, s1_cy_lo, s1_inx_lo, s1_zero_lo, s1_sat_lo;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_v       <= 1'b0;
      s1_mode    <= 1'b0;
      s1_sign_hi <= 1'b0;
      s1_sign_lo <= 1'b0;
      s1_e_hi    <= '0;
      s1_e_lo    <= '0;
      s1_frac    <= '0;
      s1_inc_hi  <= 1'b0;
      s1_cy_hi   <= 1'b0;
      s1_inx_hi  <= 1'b0;
      s1_zero_hi <= 1'b0;
      s1_sat_hi  <= 1'b0;
      s1_inc_lo  <= 1'b0;
      s1_cy_lo   <= 1'b0;
      s1_inx_lo  <= 1'b0;
      s1_zero_lo <= 1'b0;
      s1_sat_lo  <= 1'b0;
    end else if (s1_adv) begin
      s1_v <= i_valid;
      if (i_valid) begin
        s1_mode    <= i_mode;
        s1_sign_hi <= i_sign_hi;
        s1_sign_lo <= i_sign_lo;
        s1_e_hi    <= e_hi_d;
        s1_e_lo    <= e_lo_d;
        s1_frac    <= i_res53[51:0];
        s1_inc_hi  <= inc_hi_d;
        s1_cy_hi   <= cy_hi_d;
        s1_inx_hi  <= inx_hi_d;
        s1_zero_hi <= zero_hi_d;
        s1_sat_hi  <= sat_hi_d;
        s1_inc_lo  <= inc_lo_d;
        s1_cy_lo   <= cy_lo_d;
        s1_inx_lo  <= inx_lo_d;
        s1_zero_lo <= zero_lo_d;
        s1_sat_lo  <= sat_lo_d;
      end
    end
  end

  // returns {ovf, unf, inx, word[31:0]}
  function automatic logic [34:0] pack_single(input logic sign, input logic zero,
                                              input logic sat, input logic inx,
                                              input logic [12:0] e, input logic [22:0] frac);
    logic [34:0] p;
    p = {3'b000, sign, 31'd0};
    if (!zero) begin
      if ($signed(e) >= EXP_MAX_S)
        p = {3'b101, sign, (sat ? {8'hFE, {23{1'b1}}} : {8'hFF, 23'd0})};
      else if ($signed(e) <= 13'sd0)
        p = {3'b011, sign, 31'd0};
      else
        p = {2'b00, inx, sign, e[7:0], frac};
    end
    return p;
  endfunction

  logic [51:0] frac_d;
  logic [22:0] frac_sh, frac_sl;
  logic [12:0] eh, el;
  logic [34:0] pk_hi, pk_lo;
  logic [63:0] res_d;
  logic [5:0]  flg_d;

  // mantissa carry-out wraps the fraction to zero; exponent takes the carry
  assign frac_d  = s1_frac + {51'd0, s1_inc_hi};
  assign frac_sh = s1_frac[51:29] + {22'd0, s1_inc_hi};
  assign frac_sl = s1_frac[22:0] + {22'd0, s1_inc_lo};
  assign eh      = s1_e_hi + {12'd0, s1_cy_hi};
  assign el      = s1_e_lo + {12'd0, s1_cy_lo};

  assign pk_hi = pack_single(s1_sign_hi, s1_zero_hi, s1_sat_hi, s1_inx_hi, eh, frac_sh);
  assign pk_lo = pack_single(s1_sign_lo, s1_zero_lo, s1_sat_lo, s1_inx_lo, el, frac_sl);

  always_comb begin
    res_d = '0;
    flg_d = '0;
    if (s1_mode) begin
      res_d = {s1_sign_hi, 63'd0};
      if (!s1_zero_hi) begin
        if ($signed(eh) >= EXP_MAX_D) begin
          res_d = s1_sat_hi ? {s1_sign_hi, 11'h7FE, {52{1'b1}}} : {s1_sign_hi, 11'h7FF, 52'd0};
          flg_d[F_OVF_HI] = 1'b1;
          flg_d[F_INX_HI] = 1'b1;
        end else if ($signed(eh) <= 13'sd0) begin
          flg_d[F_UNF_HI] = 1'b1;
          flg_d[F_INX_HI] = 1'b1;
        end else begin
          res_d = {s1_sign_hi, eh[10:0], frac_d};
          flg_d[F_INX_HI] = s1_inx_hi;
        end
      end
    end else begin
      res_d = {pk_hi[31:0], pk_lo[31:0]};
      flg_d = {pk_hi[34:32], pk_lo[34:32]};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_flags  <= '0;
    end else if (s2_adv) begin
      o_valid <= s1_v;
      if (s1_v) begin
        o_result <= res_d;
        o_flags  <= flg_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
// Self-checking bench for fp_round_pack: directed vectors, backpressure, reset, random traffic.
module tb_fp_round_pack;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic        i_mode = 1'b0;
  logic [52:0] i_res53 = '0;
  logic [4:0]  i_z24 = '0;
  logic [4:0]  i_z29 = '0;
  logic [5:0]  i_z52 = '0;
  logic [12:0] i_exp_hi = '0;
  logic [12:0] i_exp_lo = '0;
  logic        i_sign_hi = 1'b0, i_sign_lo = 1'b0;
  logic        i_rnd_hi = 1'b0, i_stk_hi = 1'b0, i_rnd_lo = 1'b0, i_stk_lo = 1'b0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [63:0] o_result;
  logic [5:0]  o_flags;

  fp_round_pack dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_mode   (i_mode),
    .i_res53  (i_res53),
    .i_z24    (i_z24),
    .i_z29    (i_z29),
    .i_z52    (i_z52),
    .i_exp_hi (i_exp_hi),
    .i_exp_lo (i_exp_lo),
    .i_sign_hi(i_sign_hi),
    .i_sign_lo(i_sign_lo),
    .i_rnd_hi (i_rnd_hi),
    .i_stk_hi (i_stk_hi),
    .i_rnd_lo (i_rnd_lo),
    .i_stk_lo (i_stk_lo),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_result (o_result),
    .o_flags  (o_flags)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] q_res[$];
  logic [5:0]  q_flg[$];
  bit          use_fixed = 1'b0;
  logic [63:0] fix_res;
  logic [5:0]  fix_flg;
  bit          hold_prev = 1'b0;
  logic [63:0] prev_res;
  logic [5:0]  prev_flg;
  int          acc_cnt = 0;
  bit          took = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // One IEEE lane from real-number rules: m is the integer significand of mb bits.
  task automatic lane_ref(input logic [63:0] m, input int mb, input int eb, input bit g,
                          input bit s, input int e_in, input bit sign,
                          output logic [63:0] word, output logic [2:0] fl);
    logic [63:0] m2;
    int e, fb, emax;
    fb   = mb - 1;
    emax = (1 << eb) - 1;
    e    = e_in;
    word = 64'(sign) << (eb + fb);
    fl   = 3'b000;
    if (m == 0) return;
    m2 = m + ((g && (s || (m % 2 == 1))) ? 64'd1 : 64'd0);
    if (m2 >= (64'd1 << mb)) begin
      m2 = m2 / 2;
      e  = e + 1;
    end
    if (e >= emax) begin
      word = word | (64'(emax) << fb);
      fl   = 3'b101;
    end else if (e <= 0) begin
      fl = 3'b011;
    end else begin
      word = word | (64'(e) << fb) | (m2 % (64'd1 << fb));
      fl   = {2'b00, g | s};
    end
  endtask

  task automatic ref_model(output logic [63:0] res, output logic [5:0] fl);
    logic [63:0] wh, wl, r;
    logic [2:0]  fh, flo;
    int eh, el;
    r  = 64'(i_res53);
    eh = int'($signed(i_exp_hi));
    el = int'($signed(i_exp_lo));
    if (i_mode) begin
      lane_ref(r, 53, 11, i_rnd_hi, i_stk_hi, eh - int'(i_z52), i_sign_hi, wh, fh);
      res = wh;
      fl  = {fh, 3'b000};
    end else begin
      lane_ref(r >> 29, 24, 8, ((r >> 28) % 2) == 1,
               (((r >> 24) % 16) != 0) || i_rnd_hi || i_stk_hi,
               eh - int'(i_z29), i_sign_hi, wh, fh);
      lane_ref(r % (64'd1 << 24), 24, 8, i_rnd_lo, i_stk_lo, el - int'(i_z24), i_sign_lo, wl, flo);
      res = {wh[31:0], wl[31:0]};
      fl  = {fh, flo};
    end
  endtask

  task automatic cycle();
    logic [63:0] r;
    logic [5:0]  f;
    #1;
    took = 1'b0;
    if (hold_prev) begin
      chk("hold_valid", 64'(o_valid), 64'd1);
      chk("hold_result", o_result, prev_res);
      chk("hold_flags", 64'(o_flags), 64'(prev_flg));
    end
    if (i_valid && i_ready) begin
      if (use_fixed) begin
        r = fix_res;
        f = fix_flg;
      end else begin
        ref_model(r, f);
      end
      q_res.push_back(r);
      q_flg.push_back(f);
      took = 1'b1;
      acc_cnt++;
    end
    if (o_valid && o_ready) begin
      if (q_res.size() == 0) begin
        chk("spurious_out", 64'(o_valid), 64'd0);
      end else begin
        r = q_res.pop_front();
        f = q_flg.pop_front();
        chk("out_result", o_result, r);
        chk("out_flags", 64'(o_flags), 64'(f));
      end
    end
    hold_prev = o_valid && !o_ready;
    prev_res  = o_result;
    prev_flg  = o_flags;
    @(negedge i_clk);
  endtask

  task automatic set_in(input bit mode, input logic [52:0] r, input logic [5:0] z52,
                        input int eh, input int el, input bit sh, input bit sl,
                        input bit rh, input bit kh);
    i_mode = mode; i_res53 = r; i_z52 = z52; i_z29 = '0; i_z24 = '0;
    i_exp_hi = 13'(eh); i_exp_lo = 13'(el);
    i_sign_hi = sh; i_sign_lo = sl;
    i_rnd_hi = rh; i_stk_hi = kh; i_rnd_lo = 1'b0; i_stk_lo = 1'b0;
  endtask

  task automatic rand_beat();
    int k;
    logic [23:0] hi, lo;
    i_mode = 1'($urandom_range(0, 1));
    k = int'($urandom_range(0, 9));
    if (i_mode) begin
      if (k == 0)      i_res53 = '0;
      else if (k == 1) i_res53 = {53{1'b1}};
      else             i_res53 = {1'b1, 20'($urandom), 32'($urandom)};
      i_exp_hi = 13'(int'($urandom_range(0, 2120)) - 20);
    end else begin
      hi = (k == 0) ? 24'd0 : (k == 1) ? 24'hFFFFFF : {1'b1, 23'($urandom)};
      k  = int'($urandom_range(0, 9));
      lo = (k == 0) ? 24'd0 : (k == 1) ? 24'hFFFFFF : {1'b1, 23'($urandom)};
      i_res53  = {hi, 5'($urandom), lo};
      i_exp_hi = 13'(int'($urandom_range(0, 290)) - 20);
    end
    i_exp_lo  = 13'(int'($urandom_range(0, 290)) - 20);
    i_z52     = 6'($urandom_range(0, (k == 2) ? 63 : 2));
    i_z29     = 5'($urandom_range(0, (k == 3) ? 31 : 2));
    i_z24     = 5'($urandom_range(0, (k == 4) ? 31 : 2));
    i_sign_hi = 1'($urandom);
    i_sign_lo = 1'($urandom);
    i_rnd_hi  = 1'($urandom);
    i_stk_hi  = 1'($urandom);
    i_rnd_lo  = 1'($urandom);
    i_stk_lo  = 1'($urandom);
  endtask

  task automatic drain();
    o_ready = 1'b1;
    i_valid = 1'b0;
    for (int n = 0; n < 20 && q_res.size() != 0; n++) cycle();
    chk("drain_empty", 64'(q_res.size()), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_result", o_result, 64'd0);
    chk("rst_o_flags", 64'(o_flags), 64'd0);
    chk("rst_i_ready", 64'(i_ready), 64'd1);
    i_rst = 1'b0;
    @(negedge i_clk);

    // double 1.0, latency check
    use_fixed = 1'b1;
    o_ready = 1'b1;
    set_in(1'b1, 53'd1 << 52, 6'd0, 1023, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    fix_res = 64'h3FF0000000000000; fix_flg = 6'b000000;
    i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    chk("lat_cycle1", 64'(o_valid), 64'd0);
    cycle();
    chk("lat_cycle2", 64'(o_valid), 64'd1);

    i_valid = 1'b1;
    set_in(1'b1, {53{1'b1}}, 6'd0, 1023, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    fix_res = 64'h4000000000000000; fix_flg = 6'b001000;
    cycle();
    set_in(1'b0, (53'h800000 << 29) | 53'hC00000, 6'd0, 127, 128, 1'b0, 1'b1, 1'b0, 1'b0);
    fix_res = 64'h3F800000C0400000; fix_flg = 6'b000000;
    cycle();
    set_in(1'b1, 53'd1 << 52, 6'd0, 2047, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    fix_res = 64'h7FF0000000000000; fix_flg = 6'b101000;
    cycle();
    set_in(1'b1, 53'd1 << 52, 6'd5, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    fix_res = 64'h0000000000000000; fix_flg = 6'b011000;
    cycle();
    drain();
    use_fixed = 1'b0;

    // backpressure: four back-to-back beats against a stalled sink
    o_ready = 1'b0;
    acc_cnt = 0;
    took = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (took && acc_cnt < 4) rand_beat();
      i_valid = (acc_cnt < 4);
      cycle();
    end
    chk("bp_accepted", 64'(acc_cnt), 64'd2);
    chk("bp_i_ready", 64'(i_ready), 64'd0);
    o_ready = 1'b1;
    for (int k = 0; k < 20 && acc_cnt < 4; k++) begin
      if (took) rand_beat();
      i_valid = 1'b1;
      cycle();
    end
    i_valid = 1'b0;
    chk("bp_all_in", 64'(acc_cnt), 64'd4);
    drain();

    // asynchronous reset with two beats in flight
    o_ready = 1'b0;
    acc_cnt = 0;
    took = 1'b1;
    for (int k = 0; k < 10 && acc_cnt < 2; k++) begin
      if (took) rand_beat();
      i_valid = 1'b1;
      cycle();
    end
    i_valid = 1'b0;
    cycle();
    chk("rst_pre_valid", 64'(o_valid), 64'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(o_valid), 64'd0);
    chk("rst_async_result", o_result, 64'd0);
    chk("rst_async_flags", 64'(o_flags), 64'd0);
    q_res.delete();
    q_flg.delete();
    hold_prev = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rst_no_stale", 64'(o_valid), 64'd0);
    end
    chk("rst_i_ready_after", 64'(i_ready), 64'd1);

    // random traffic with random stalls
    for (int k = 0; k < 400; k++) begin
      rand_beat();
      i_valid = ($urandom_range(0, 4) != 0);
      o_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
